// File: rtl/tetris_board_if.sv
// Bus bundle for tetris_board: renderer read port, engine write port,
// and row-clear control/status.
interface tetris_board_if #(
    parameter int KIND_W = 3
);
    logic [3:0]        rd_x;
    logic [4:0]        rd_y;
    logic [KIND_W-1:0] rd_kind;
    logic              wr_en;
    logic [3:0]        wr_x;
    logic [4:0]        wr_y;
    logic [KIND_W-1:0] wr_kind;
    logic              wr_ready;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic [4:0]        lines_cleared;

    modport master (
        output rd_x, rd_y, wr_en, wr_x, wr_y, wr_kind, clear_start,
        input  rd_kind, wr_ready, clear_busy, clear_done, lines_cleared
    );

    modport slave (
        input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_kind, clear_start,
        output rd_kind, wr_ready, clear_busy, clear_done, lines_cleared
    );
endinterface

// File: rtl/tetris_board.sv
// Tetris playfield storage with registered read port and row-clear FSM.
// Optional BOARD_RD_BYPASS_EN: same-edge write-to-read forwarding.
module tetris_board #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int KIND_W = 3
) (
    input logic           clk,
    input logic           reset,
    tetris_board_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    localparam logic [4:0] XLIM = 5'(WIDTH);
    localparam logic [4:0] YLIM = 5'(HEIGHT);
    localparam logic [4:0] RTOP = 5'(HEIGHT - 1);

    state_t            state;
    logic [4:0]        r;
    logic [KIND_W-1:0] cells [HEIGHT][WIDTH];
    logic [KIND_W-1:0] rd_kind;
    logic              busy;
    logic              done;
    logic              ready;
    logic [4:0]        lines;
    logic              wr_in;
    logic              rd_in;
    logic              wr_acc;
    logic              row_full;

    assign wr_in  = ({1'b0, bus.wr_x} < XLIM) && (bus.wr_y < YLIM);
    assign rd_in  = ({1'b0, bus.rd_x} < XLIM) && (bus.rd_y < YLIM);
    assign wr_acc = bus.wr_en && ready && wr_in;

    assign bus.rd_kind       = rd_kind;
    assign bus.wr_ready      = ready;
    assign bus.clear_busy    = busy;
    assign bus.clear_done    = done;
    assign bus.lines_cleared = lines;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            if (cells[r][c] == '0) row_full = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HEIGHT; i++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    cells[i][c] <= '0;
                end
            end
            state <= IDLE;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
            lines <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_acc) cells[bus.wr_y][bus.wr_x] <= bus.wr_kind;
                    if (bus.clear_start) begin
                        state <= SCAN;
                        r     <= RTOP;
                        lines <= '0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state <= SHIFT;
                    end else if (r == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        r <= r - 5'd1;
                    end
                end
                SHIFT: begin
                    // rows 0..r drop by one; r is rescanned next
                    for (int i = 1; i < HEIGHT; i++) begin
                        if (5'(i) <= r) begin
                            for (int c = 0; c < WIDTH; c++) begin
                                cells[i][c] <= cells[i-1][c];
                            end
                        end
                    end
                    for (int c = 0; c < WIDTH; c++) begin
                        cells[0][c] <= '0;
                    end
                    lines <= lines + 5'd1;
                    state <= SCAN;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_kind <= '0;
        end else if (!rd_in) begin
            rd_kind <= '0;
`ifdef BOARD_RD_BYPASS_EN
        end else if (wr_acc && bus.wr_x == bus.rd_x && bus.wr_y == bus.rd_y) begin
            rd_kind <= bus.wr_kind;
`endif
        end else begin
            rd_kind <= cells[bus.rd_y][bus.rd_x];
        end
    end
endmodule

// File: doc/tetris_board.md
# tetris_board

Playfield storage and row-clear engine for the Tetris game. The renderer queries it at VGA pixel rate through a registered (x, y) → kind read port, and the game engine places locked pieces through a single-cell write port. On request, a scan/shift state machine removes full rows, collapses the rows above them, and reports how many rows it removed for scoring. All logic runs in the 50 MHz game clock domain.

## Interface
- `WIDTH`, default 10: columns. x range is 0..WIDTH-1.
- `HEIGHT`, default 20: rows. y = 0 is the top row. HEIGHT must be ≤ 31.
- `KIND_W`, default 3: bits per cell. Value 0 means empty; 1..7 are piece kinds.

Ports (clock and reset first):
- `clk`, in, 1: game clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `rd_x`, in, 4: renderer query column.
- `rd_y`, in, 5: renderer query row.
- `rd_kind`, out, KIND_W: registered cell contents for the query sampled on the previous edge.
- `wr_en`, in, 1: write request.
- `wr_x`, in, 4: write column.
- `wr_y`, in, 5: write row.
- `wr_kind`, in, KIND_W: value to write.
- `wr_ready`, out, 1: high when writes are accepted. Equals NOT `clear_busy`.
- `clear_start`, in, 1: single-cycle request to run a row clear.
- `clear_busy`, out, 1: row clear in progress.
- `clear_done`, out, 1: one-cycle pulse on the last busy cycle.
- `lines_cleared`, out, 5: number of rows removed by the last clear. Held until the next clear starts.

## Operation
- Storage is a WIDTH×HEIGHT array of KIND_W-bit registers. Reset clears every cell to 0.
- Read path:
  - `rd_kind <= cell[rd_y][rd_x]` on every edge, in every state.
  - An out-of-range coordinate (`rd_x` ≥ WIDTH or `rd_y` ≥ HEIGHT) returns 0.
- Write path:
  - A write is accepted when `wr_en` is high and `wr_ready` is high.
  - An out-of-range coordinate is ignored with no side effects.
  - A write requested while busy is dropped, not queued.
- FSM states are IDLE, SCAN, SHIFT and DONE, with a row pointer `r`.
  - IDLE, `clear_start` high: go to SCAN with `r` = HEIGHT-1 and `lines_cleared` = 0.
  - SCAN, row `r` full (every cell nonzero): go to SHIFT.
  - SCAN, row `r` not full and `r` = 0: go to DONE.
  - SCAN, row `r` not full and `r` > 0: decrement `r`, stay in SCAN.
  - SHIFT: for every row i ≤ `r`, row i ← row i-1. Row 0 ← all zero. Increment `lines_cleared`. Return to SCAN with the same `r`, so the row that dropped in is rescanned.
  - DONE: assert `clear_done` and go to IDLE.
- `clear_busy` is high in SCAN, SHIFT and DONE.
- `clear_start` while busy is ignored.
- Simultaneous `wr_en` and `clear_start` in IDLE: the write commits on that edge, and the first SCAN sees the written value.
- `lines_cleared` never exceeds HEIGHT, so 5 bits do not overflow.

## Timing
- Reset values of all outputs are 0, except `wr_ready`, which is 1. The FSM resets to IDLE with `r` = 0.
- An asynchronous reset mid-clear aborts immediately and clears the array.
- Read latency is 1 clock.
- A write is visible to a read sampled on the next edge. The same-edge case is covered under Configuration.
- Clear latency: with k full rows removed, `clear_busy` is high for exactly HEIGHT + 2k + 1 cycles, starting the cycle after `clear_start` is sampled. `clear_done` is high on the last of those cycles.
- `wr_ready` falls in the first busy cycle and rises in the cycle after `clear_done`.

## Configuration
- `BOARD_RD_BYPASS_EN` defined: when a write is accepted on the same edge as a read of the same in-range cell, `rd_kind` returns `wr_kind`.
- `BOARD_RD_BYPASS_EN` undefined: in that same case, `rd_kind` returns the old cell contents.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then read all 200 cells: `rd_kind` = 0 one cycle after each query, `wr_ready` = 1, `clear_busy` = 0.
- Write kind 5 at (3,7), read (3,7) next cycle: `rd_kind` = 5. Write kind 2 at (12,7) (out of range): no cell changes.
- Fill row 19 entirely and put kind 4 at (0,18), then pulse `clear_start`:
  - `clear_busy` high 23 cycles and `clear_done` on cycle 23.
  - `lines_cleared` = 1.
  - (0,19) = 4 and row 0 all 0.
- Fill rows 16–19, then clear: busy 29 cycles, `lines_cleared` = 4, board entirely 0.
- During a clear, assert `wr_en` at (1,1) with kind 3: the write is dropped, and (1,1) reads 0 after `clear_done`.
- Same-cycle write and read of (2,2) with kind 6:
  - Built with `BOARD_RD_BYPASS_EN`: `rd_kind` = 6.
  - Built without it: `rd_kind` = 0.
- Assert `reset` mid-SHIFT: all outputs return to their reset values within the same cycle, and a subsequent read of any cell returns 0.
